histeq_cdf_gen: RTL and testbench

//  Producer side of the cumulative-histogram stream used by histogram equalisation. Counts per-frame gray-level

---
 rtl/histeq_cdf_gen.sv | 171 +++++++++++++++++
 tb/tb_histeq_cdf_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/histeq_cdf_gen.sv
// Cumulative-histogram producer for histogram equalisation: counts gray levels per frame into a
// 256-bin RAM, then streams the 256 running sums (levels 0..255) to the mapping stage.
module histeq_cdf_gen #(
    parameter int unsigned C_CNT_W = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               per_img_vsync_i,
    input  logic               per_img_href_i,
    input  logic [7:0]         per_img_gray_i,
    output logic [7:0]         pixel_level_o,
    output logic [C_CNT_W-1:0] pixel_level_acc_num_o,
    output logic               pixel_level_valid_o,
    output logic               busy_o,
    output logic               frame_dropped_o
);

    localparam logic [C_CNT_W-1:0] CntMax = '1;

    typedef enum logic [2:0] {StInit, StIdle, StCount, StDrain, StAcc} state_e;

    state_e state_q, state_d;
    logic [8:0] idx_q, idx_d;
    logic       vs_q;
    logic       rise, fall;

    // Stage 0: RAM read issue. Stage 1: read data back, write-back and accumulation.
    logic       s0_vld, s0_acc;
    logic [7:0] rd_addr;
    logic       s1_vld_q, s1_acc_q;
    logic [7:0] s1_addr_q;

    logic [C_CNT_W-1:0] mem [256];
    logic [C_CNT_W-1:0] rdata_q;

    logic               we;
    logic [7:0]         waddr;
    logic [C_CNT_W-1:0] wdata;
    logic               wr_vld_q;
    logic [7:0]         wr_addr_q;
    logic [C_CNT_W-1:0] wr_data_q;

    logic [C_CNT_W-1:0] bin_cur, bin_inc, sum_sat;
    logic [C_CNT_W:0]   sum_ext;
    logic [C_CNT_W-1:0] sum_q;

    logic [7:0]         level_q;
    logic [C_CNT_W-1:0] acc_num_q;
    logic               valid_q, dropped_q;

    assign rise = per_img_vsync_i & ~vs_q;
    assign fall = ~per_img_vsync_i & vs_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        s0_vld  = 1'b0;
        s0_acc  = 1'b0;
        rd_addr = per_img_gray_i;
        unique case (state_q)
            StInit: begin
                if (idx_q[7:0] == 8'hff) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 9'd1;
                end
            end
            StIdle: begin
                if (rise) begin
                    state_d = StCount;
                    s0_vld  = per_img_href_i;
                end
            end
            StCount: begin
                s0_vld = per_img_href_i & per_img_vsync_i;
                if (fall) begin
                    state_d = StDrain;
                end
            end
            // One idle cycle lets the last counting write retire before bin 0 is read.
            StDrain: begin
                state_d = StAcc;
                idx_d   = '0;
            end
            StAcc: begin
                if (!idx_q[8]) begin
                    s0_vld  = 1'b1;
                    s0_acc  = 1'b1;
                    rd_addr = idx_q[7:0];
                    idx_d   = idx_q + 9'd1;
                end
                if (valid_q && level_q == 8'hff) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    // The RAM returns pre-write data on a same-edge collision, so the previous write is forwarded.
    assign bin_cur = (wr_vld_q && wr_addr_q == s1_addr_q) ? wr_data_q : rdata_q;
    assign bin_inc = (bin_cur == CntMax) ? CntMax : bin_cur + 1'b1;
    assign sum_ext = {1'b0, sum_q} + {1'b0, bin_cur};
    assign sum_sat = sum_ext[C_CNT_W] ? CntMax : sum_ext[C_CNT_W-1:0];

    always_comb begin
        we    = 1'b0;
        waddr = s1_addr_q;
        wdata = '0;
        if (state_q == StInit) begin
            we    = 1'b1;
            waddr = idx_q[7:0];
        end else if (s1_vld_q) begin
            we    = 1'b1;
            wdata = s1_acc_q ? '0 : bin_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (s0_vld) begin
            rdata_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StInit;
            idx_q     <= '0;
            vs_q      <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_acc_q  <= 1'b0;
            s1_addr_q <= '0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            sum_q     <= '0;
            level_q   <= '0;
            acc_num_q <= '0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            vs_q      <= per_img_vsync_i;
            s1_vld_q  <= s0_vld;
            s1_acc_q  <= s0_acc;
            s1_addr_q <= rd_addr;
            wr_vld_q  <= we;
            wr_addr_q <= waddr;
            wr_data_q <= wdata;
            valid_q   <= s1_vld_q & s1_acc_q;
            dropped_q <= rise & (state_q inside {StInit, StDrain, StAcc});
            if (s1_vld_q && s1_acc_q) begin
                level_q   <= s1_addr_q;
                acc_num_q <= sum_sat;
                sum_q     <= (s1_addr_q == 8'hff) ? '0 : sum_sat;
            end
        end
    end

    assign pixel_level_o         = level_q;
    assign pixel_level_acc_num_o = acc_num_q;
    assign pixel_level_valid_o   = valid_q;
    assign busy_o                = state_q inside {StInit, StDrain, StAcc};
    assign frame_dropped_o       = dropped_q;

endmodule

// File: tb/tb_histeq_cdf_gen.sv
// Randomised bench: two instances (20-bit and 4-bit counters) share stimulus; each burst is
// compared with a cumulative histogram computed directly from the pixels sent.
module tb_histeq_cdf_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0, href = 1'b0;
    logic [7:0]  gray = '0;

    logic [7:0]  lvl_a, lvl_b;
    logic [19:0] acc_a;
    logic [3:0]  acc_b;
    logic        vld_a, vld_b, busy_a, busy_b, drop_a, drop_b;

    histeq_cdf_gen #(.C_CNT_W(20)) dut_a (
        .clk(clk), .rst_n(rst_n), .per_img_vsync_i(vsync), .per_img_href_i(href),
        .per_img_gray_i(gray), .pixel_level_o(lvl_a), .pixel_level_acc_num_o(acc_a),
        .pixel_level_valid_o(vld_a), .busy_o(busy_a), .frame_dropped_o(drop_a)
    );

    histeq_cdf_gen #(.C_CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .per_img_vsync_i(vsync), .per_img_href_i(href),
        .per_img_gray_i(gray), .pixel_level_o(lvl_b), .pixel_level_acc_num_o(acc_b),
        .pixel_level_valid_o(vld_b), .busy_o(busy_b), .frame_dropped_o(drop_b)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int lvl; longint acc;} ent_t;
    ent_t   qa[$], qb[$];
    int     cyc = 0;
    int     nd_a = 0, nd_b = 0;
    int     n_checks = 0, n_errors = 0;
    int     px[$];
    int     fall_cyc;
    longint exp_a[256], exp_b[256];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (vld_a) qa.push_back('{cyc, int'(lvl_a), longint'(acc_a)});
            if (vld_b) qb.push_back('{cyc, int'(lvl_b), longint'(acc_b)});
            if (drop_a) nd_a++;
            if (drop_b) nd_b++;
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cumulative histogram with each bin and the running sum clamped at max.
    task automatic build_model(input longint max, output longint e[256]);
        longint h[256];
        longint run;
        foreach (h[k]) h[k] = 0;
        foreach (px[i]) h[px[i]]++;
        run = 0;
        for (int k = 0; k < 256; k++) begin
            run  = run + ((h[k] > max) ? max : h[k]);
            run  = (run > max) ? max : run;
            e[k] = run;
        end
    endtask

    task automatic reset_and_init();
        int ok;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", vld_a | vld_b, 0);
        check("rst_level", lvl_a, 0);
        check("rst_acc", acc_a, 0);
        check("rst_drop", drop_a | drop_b, 0);
        check("rst_busy", busy_a & busy_b, 1);
        rst_n = 1'b1;
        ok = 0;
        for (int i = 0; i < 256; i++) begin
            if (busy_a && busy_b && !vld_a && !vld_b) ok++;
            @(negedge clk);
        end
        check("init_busy_cycles", ok, 256);
        check("init_done_busy", busy_a | busy_b, 0);
    endtask

    task automatic drive_frame(input int gap_pct);
        qa.delete(); qb.delete();
        nd_a = 0; nd_b = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vsync = 1'b0; href = 1'b1; gray = 8'($urandom_range(255));
        end
        // First pixel shares the vsync-rise cycle.
        @(negedge clk);
        vsync = 1'b1; href = 1'b1; gray = 8'(px[0]);
        for (int i = 1; i < px.size(); i++) begin
            @(negedge clk);
            while ($urandom_range(99) < gap_pct) begin
                href = 1'b0; gray = 8'($urandom_range(255));
                @(negedge clk);
            end
            href = 1'b1; gray = 8'(px[i]);
        end
        @(negedge clk);
        vsync = 1'b0; href = 1'($urandom_range(1)); gray = 8'($urandom_range(255));
        fall_cyc = cyc;
        check("busy_in_count", busy_a, 0);
        @(negedge clk);
        href = 1'b0;
        check("busy_after_fall", busy_a & busy_b, 1);
    endtask

    task automatic run_frame(input int gap_pct, input bit drop);
        build_model(64'd1048575, exp_a);
        build_model(64'd15, exp_b);
        drive_frame(gap_pct);
        if (drop) begin
            repeat (20) @(negedge clk);
            vsync = 1'b1;
            for (int i = 0; i < 300; i++) begin
                href = 1'($urandom_range(1)); gray = 8'($urandom_range(255));
                @(negedge clk);
            end
            vsync = 1'b0; href = 1'b0;
        end
        for (int t = 0; t < 700 && !(qa.size() >= 256 && qb.size() >= 256); t++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("n_valid_a", qa.size(), 256);
        check("n_valid_b", qb.size(), 256);
        check("n_drop_a", nd_a, drop);
        check("n_drop_b", nd_b, drop);
        check("idle_after_acc", busy_a | busy_b, 0);
        if (qa.size() >= 256) begin
            check("first_latency", qa[0].cyc - fall_cyc, 4);
            check("contiguous", qa[255].cyc - qa[0].cyc, 255);
        end
        for (int k = 0; k < 256 && k < qa.size(); k++) begin
            check("level_a", qa[k].lvl, k);
            check("cdf_a", qa[k].acc, exp_a[k]);
        end
        for (int k = 0; k < 256 && k < qb.size(); k++) begin
            check("level_b", qb[k].lvl, k);
            check("cdf_b", qb[k].acc, exp_b[k]);
        end
    endtask

    initial begin
        reset_and_init();

        px.delete(); repeat (16) px.push_back(10);
        run_frame(0, 1'b0);

        px.delete(); for (int i = 0; i < 256; i++) px.push_back(i);
        run_frame(0, 1'b0);

        px = '{5, 5, 6, 5, 5, 6};
        run_frame(0, 1'b0);

        px.delete(); repeat (16) px.push_back(0);
        run_frame(0, 1'b0);
        px.delete(); repeat (16) px.push_back(255);
        run_frame(20, 1'b0);

        px.delete(); repeat (40) px.push_back($urandom_range(255));
        run_frame(10, 1'b1);
        px.delete(); repeat (30) px.push_back($urandom_range(7));
        run_frame(10, 1'b0);

        px.delete(); repeat (20) px.push_back(0);
        run_frame(0, 1'b0);

        // Reset asserted in the middle of the cumulative burst.
        drive_frame(0);
        for (int t = 0; t < 400 && qa.size() < 100; t++) @(negedge clk);
        check("mid_acc_reached", qa.size() >= 100, 1);
        reset_and_init();

        for (int f = 0; f < 4; f++) begin
            int n = $urandom_range(1, 400);
            bit narrow = 1'($urandom_range(1));
            px.delete();
            for (int i = 0; i < n; i++) px.push_back(narrow ? $urandom_range(3) : $urandom_range(255));
            run_frame(30, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
